// File: rtl/pwd_pkg.sv
// Shared types and constants for the password scan controller.
package pwd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_MATCH = 3'd3,
    ST_FAIL  = 3'd4,
    ST_LOCK  = 3'd5
  } state_t;

  // memory read latency in cycles; compare pipeline depth follows it
  localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/pwd_addr_counter.sv
// Clearable/loadable up-counter with terminal-count flag (scan address, lock timer).
module pwd_addr_counter #(
  parameter int W  = 4,
  parameter int TC = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (clr)  count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count + 1'b1;
  end

  assign tc = (count == W'(TC));

endmodule

// File: rtl/pwd_scan_ctrl.sv
// Password checker: latches a code, scans a sync-read code memory, pulses match/fail.
// Define PWD_LOCKOUT_EN to add the attempt counter and keypad lockout.
module pwd_scan_ctrl
  import pwd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000,
  localparam int TRY_W = ($clog2(MAX_TRIES+1) < 2) ? 2 : $clog2(MAX_TRIES+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] senha,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              match,
  output logic              fail,
  output logic              locked,
  output logic [TRY_W-1:0]  tries_left
);

  state_t state, next;
  logic [DATA_W-1:0] code_q;
  logic [MEM_RD_LAT:0] vld_pipe;
  logic cmp_valid, hit, addr_tc;

  // vld_pipe[0] marks an address issued this cycle; the tap lines up with mem_data
  assign vld_pipe[0] = (state == ST_SCAN);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_pipe[MEM_RD_LAT:1] <= '0;
    else        vld_pipe[MEM_RD_LAT:1] <= vld_pipe[MEM_RD_LAT-1:0];
  end
  assign cmp_valid = vld_pipe[MEM_RD_LAT];
  assign hit       = cmp_valid && (mem_data == code_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         code_q <= '0;
    else if (state == ST_IDLE && enter) code_q <= senha;
  end

  pwd_addr_counter #(.W(ADDR_W), .TC(DEPTH-1)) u_addr (
    .clk(clk), .reset(reset),
    .clr(next != ST_SCAN), .load(1'b0), .load_val('0),
    .en(state == ST_SCAN),
    .count(mem_addr), .tc(addr_tc)
  );

`ifdef PWD_LOCKOUT_EN
  localparam int LOCK_W = ($clog2(LOCK_CYCLES+1) < 1) ? 1 : $clog2(LOCK_CYCLES+1);
  logic [LOCK_W-1:0] lock_cnt;
  logic lock_tc;
  logic [TRY_W-1:0] tries_q;

  pwd_addr_counter #(.W(LOCK_W), .TC(LOCK_CYCLES-1)) u_lock (
    .clk(clk), .reset(reset),
    .clr(state != ST_LOCK), .load(1'b0), .load_val('0),
    .en(state == ST_LOCK),
    .count(lock_cnt), .tc(lock_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            tries_q <= TRY_W'(MAX_TRIES);
    else if (state == ST_MATCH)            tries_q <= TRY_W'(MAX_TRIES);
    else if (state == ST_FAIL)             tries_q <= tries_q - 1'b1;
    else if (state == ST_LOCK && lock_tc)  tries_q <= TRY_W'(MAX_TRIES);
  end

  assign tries_left = tries_q;
  assign locked     = (state == ST_LOCK);
`else
  assign tries_left = TRY_W'(MAX_TRIES);
  assign locked     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:  if (enter) next = ST_SCAN;
      ST_SCAN: begin
        if (hit)          next = ST_MATCH;
        else if (addr_tc) next = ST_DRAIN;
      end
      ST_DRAIN: next = hit ? ST_MATCH : ST_FAIL;
      ST_MATCH: next = ST_IDLE;
`ifdef PWD_LOCKOUT_EN
      // tries_q still holds the pre-decrement value while in FAIL
      ST_FAIL:  next = (tries_q <= TRY_W'(1)) ? ST_LOCK : ST_IDLE;
      ST_LOCK:  if (lock_tc) next = ST_IDLE;
`else
      ST_FAIL:  next = ST_IDLE;
`endif
      default:  next = ST_IDLE;
    endcase
  end

  assign busy  = (state != ST_IDLE);
  assign match = (state == ST_MATCH);
  assign fail  = (state == ST_FAIL);

endmodule

// File: tb/tb_pwd_scan_ctrl.sv
// Directed bench for pwd_scan_ctrl; covers the lockout build when PWD_LOCKOUT_EN is defined.
module tb_pwd_scan_ctrl;
  localparam int DEPTH = 16;

  logic       clk = 1'b0, reset = 1'b0, enter = 1'b0;
  logic [7:0] senha = 8'h00, mem_data;
  logic [3:0] mem_addr;
  logic       busy, match, fail, locked;
  logic [1:0] tries_left;
  logic [7:0] mem [DEPTH];
  int errors = 0, checks = 0;
  int tm, tf, nm, nf;

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem[mem_addr];

  pwd_scan_ctrl dut (
    .clk(clk), .reset(reset), .enter(enter), .senha(senha), .mem_data(mem_data),
    .mem_addr(mem_addr), .busy(busy), .match(match), .fail(fail),
    .locked(locked), .tries_left(tries_left)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // pulse enter for one edge (E0) and record result timing relative to E0
  task automatic scan(input logic [7:0] code, output int t_m, output int t_f,
                      output int n_m, output int n_f);
    t_m = -1; t_f = -1; n_m = 0; n_f = 0;
    @(negedge clk); senha = code; enter = 1'b1;
    @(posedge clk);
    @(negedge clk); enter = 1'b0;
    for (int n = 1; n <= DEPTH + 6; n++) begin
      @(posedge clk); #1;
      if (match) begin n_m++; if (t_m < 0) t_m = n; end
      if (fail)  begin n_f++; if (t_f < 0) t_f = n; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h40 + 8'(i);
    #1;
    chk("rst_busy", busy, 0);   chk("rst_match", match, 0); chk("rst_fail", fail, 0);
    chk("rst_locked", locked, 0); chk("rst_addr", mem_addr, 0); chk("rst_tries", tries_left, 3);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // hit at address 5
    mem[5] = 8'hA7;
    scan(8'hA7, tm, tf, nm, nf);
    chk("t1_time", tm, 7); chk("t1_nmatch", nm, 1); chk("t1_nfail", nf, 0);
    chk("t1_busy", busy, 0); chk("t1_addr", mem_addr, 0);

    // no hit
    scan(8'h3C, tm, tf, nm, nf);
    chk("t2_time", tf, 17); chk("t2_nfail", nf, 1); chk("t2_nmatch", nm, 0);
    chk("t2_busy", busy, 0);
`ifdef PWD_LOCKOUT_EN
    chk("t2_tries", tries_left, 2);
`else
    chk("t2_tries", tries_left, 3);
`endif

    // duplicates at first and last address, then last-only (hit in DRAIN)
    mem[0] = 8'h11; mem[15] = 8'h11;
    scan(8'h11, tm, tf, nm, nf);
    chk("t3_first_time", tm, 2); chk("t3_first_n", nm, 1); chk("t3_tries", tries_left, 3);
    mem[0] = 8'h40;
    scan(8'h11, tm, tf, nm, nf);
    chk("t3_last_time", tm, 17); chk("t3_last_n", nm, 1); chk("t3_last_nfail", nf, 0);
    mem[15] = 8'h4F;

    // senha change and enter toggle mid-scan
    tm = -1; nm = 0; nf = 0;
    @(negedge clk); senha = 8'hA7; enter = 1'b1;
    @(posedge clk);
    @(negedge clk); enter = 1'b0;
    for (int n = 1; n <= DEPTH + 6; n++) begin
      @(posedge clk); #1;
      if (match) begin nm++; if (tm < 0) tm = n; end
      if (fail) nf++;
      if (n == 2) begin senha = 8'h3C; enter = 1'b1; end
      if (n == 3) enter = 1'b0;
    end
    chk("t5_time", tm, 7); chk("t5_nmatch", nm, 1); chk("t5_nfail", nf, 0);

    // enter held high: back-to-back scans with one IDLE cycle between
    begin
      int t2;
      tm = -1; t2 = -1;
      @(negedge clk); senha = 8'hA7; enter = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 17; n++) begin
        @(posedge clk); #1;
        if (match) begin if (tm < 0) tm = n; else t2 = n; end
        if (n == 8) chk("t5_idle_gap", busy, 0);
        if (n == 9) chk("t5_rescan", busy, 1);
      end
      enter = 1'b0;
      chk("t5_held_m1", tm, 7); chk("t5_held_m2", t2, 16);
      repeat (4) @(posedge clk);
    end

    // reset mid-scan
    nm = 0; nf = 0;
    @(negedge clk); senha = 8'hA7; enter = 1'b1;
    @(posedge clk);
    @(negedge clk); enter = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    chk("t6_scan_busy", busy, 0); chk("t6_scan_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (match) nm++;
      if (fail) nf++;
    end
    chk("t6_nmatch", nm, 0); chk("t6_nfail", nf, 0);

`ifdef PWD_LOCKOUT_EN
    begin
      int k;
      scan(8'h3C, tm, tf, nm, nf); chk("t4_tries2", tries_left, 2);
      scan(8'h3C, tm, tf, nm, nf); chk("t4_tries1", tries_left, 1);
      scan(8'h3C, tm, tf, nm, nf); chk("t4_tries0", tries_left, 0);
      chk("t4_locked", locked, 1);
      // lock starts 18 edges after E0; 5 locked samples already consumed
      enter = 1'b1; k = 0;
      for (int n = 0; n < 1100; n++) begin
        @(posedge clk); #1;
        if (!locked) break;
        k++;
      end
      enter = 1'b0;
      chk("t4_lock_len", k, 995); chk("t4_reload", tries_left, 3);
      repeat (3) @(posedge clk);
      for (int i = 0; i < 3; i++) scan(8'h3C, tm, tf, nm, nf);
      repeat (10) @(posedge clk);
      @(negedge clk); reset = 1'b0; #1;
      chk("t6_lock_locked", locked, 0); chk("t6_lock_tries", tries_left, 3);
      chk("t6_lock_busy", busy, 0);
      @(negedge clk); reset = 1'b1;
    end
`else
    for (int i = 0; i < 3; i++) begin
      scan(8'h3C, tm, tf, nm, nf);
      chk("t4_nolock", locked, 0); chk("t4_notries", tries_left, 3);
    end
    chk("t4_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
